tx_readout_sequencer: RTL and testbench

Parametrised L1A readout sequencer for the layer-2 transmit path. It queues L1A-aligned events that carry data and walks a one-hot read-enable across `N_ADC` ADC readers, one event at a time. It counts fully transmitted events and reports queue overflow, missing data and out-of-order finish strobes through sticky flags and a saturating error counter. It sits between the L1A alignment logic and the per-ADC serialisers. It supersedes the fixed two-ADC manager: it adds an event queue, any ADC count, and error accounting.

---
 rtl/tx_readout_sequencer_if.sv | 33 +++
 rtl/tx_readout_sequencer.sv | 106 ++++++++++
 tb/tb_tx_readout_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/tx_readout_sequencer_if.sv
// Bus bundle between the L1A alignment logic and the readout sequencer.
// The master side drives the strobes; the slave side is the sequencer.
interface tx_readout_sequencer_if #(
   parameter int N_ADC   = 2,
   parameter int EVT_W   = 16,
   parameter int Q_DEPTH = 4,
   parameter int ERR_W   = 8
);
   localparam int PEND_W = $clog2(Q_DEPTH + 1);

   logic               L1A_Align;
   logic               need_read;
   logic               one_adc_finish_read;
   logic               err_clear;
   logic [N_ADC-1:0]   start_read;
   logic               busy;
   logic [PEND_W-1:0]  pending;
   logic [EVT_W-1:0]   evt_tx;
   logic [2:0]         error;
   logic [ERR_W-1:0]   err_cnt;
   // FSM state for checkers: 0 = IDLE, 1 = READ
   logic               dbg_state;

   modport master (
      output L1A_Align, need_read, one_adc_finish_read, err_clear,
      input  start_read, busy, pending, evt_tx, error, err_cnt, dbg_state
   );

   modport slave (
      input  L1A_Align, need_read, one_adc_finish_read, err_clear,
      output start_read, busy, pending, evt_tx, error, err_cnt, dbg_state
   );
endinterface

// File: rtl/tx_readout_sequencer.sv
// Queues L1A events that carry data and walks a one-hot read enable across
// N_ADC readers per event, with sticky error flags and a saturating counter.
module tx_readout_sequencer #(
   parameter int N_ADC   = 2,
   parameter int EVT_W   = 16,
   parameter int Q_DEPTH = 4,
   parameter int ERR_W   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   tx_readout_sequencer_if.slave bus
);
   localparam int PEND_W = $clog2(Q_DEPTH + 1);
   localparam logic [ERR_W-1:0]  ERR_MAX = '1;
   localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(Q_DEPTH);

   typedef enum logic {S_IDLE = 1'b0, S_READ = 1'b1} state_t;

   state_t             r_state, w_state_nx;
   logic [N_ADC-1:0]   r_start_read, w_start_read_nx;
   logic [PEND_W-1:0]  r_pending, w_pending_nx;
   logic [EVT_W-1:0]   r_evt_tx, w_evt_tx_nx;
   logic [2:0]         r_error, w_error_nx;
   logic [ERR_W-1:0]   r_err_cnt, w_err_cnt_nx;

   logic               w_pop, w_push_req, w_accept;
   logic [2:0]         w_err_new;
   logic [1:0]         w_inc;
   logic [ERR_W-1:0]   w_cnt_base;
   logic [ERR_W+1:0]   w_cnt_sum;

   // Queue intake and error detection, independent of the FSM
   always_comb begin
      w_pop      = (r_state == S_IDLE) && (r_pending != '0);
      w_push_req = bus.L1A_Align && bus.need_read;
      w_accept   = w_push_req && ((r_pending != PEND_FULL) || w_pop);
      w_err_new    = 3'b000;
      w_err_new[0] = bus.L1A_Align && !bus.need_read;
      w_err_new[1] = w_push_req && !w_accept;
      w_err_new[2] = bus.one_adc_finish_read && (r_state == S_IDLE);
      w_inc = {1'b0, w_err_new[0]} + {1'b0, w_err_new[1]} + {1'b0, w_err_new[2]};

      w_pending_nx = r_pending;
      if (w_accept && !w_pop)      w_pending_nx = r_pending + PEND_W'(1);
      else if (!w_accept && w_pop) w_pending_nx = r_pending - PEND_W'(1);

      // Same-cycle errors survive a clear
      w_cnt_base = bus.err_clear ? '0 : r_err_cnt;
      w_cnt_sum  = {2'b00, w_cnt_base} + {{ERR_W{1'b0}}, w_inc};
      w_err_cnt_nx = (w_cnt_sum > {2'b00, ERR_MAX}) ? ERR_MAX : w_cnt_sum[ERR_W-1:0];
      w_error_nx   = (bus.err_clear ? 3'b000 : r_error) | w_err_new;
   end

   // Read sequencing FSM
   always_comb begin
      w_state_nx      = r_state;
      w_start_read_nx = r_start_read;
      w_evt_tx_nx     = r_evt_tx;
      case (r_state)
         S_IDLE: begin
            if (w_pop) begin
               w_start_read_nx = N_ADC'(1);
               w_state_nx      = S_READ;
            end
         end
         S_READ: begin
            if (bus.one_adc_finish_read) begin
               if (r_start_read[N_ADC-1]) begin
                  w_start_read_nx = '0;
                  w_evt_tx_nx     = r_evt_tx + EVT_W'(1);
                  w_state_nx      = S_IDLE;
               end else begin
                  w_start_read_nx = r_start_read << 1;
               end
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_start_read <= '0;
         r_pending    <= '0;
         r_evt_tx     <= '0;
         r_error      <= '0;
         r_err_cnt    <= '0;
      end else begin
         r_state      <= w_state_nx;
         r_start_read <= w_start_read_nx;
         r_pending    <= w_pending_nx;
         r_evt_tx     <= w_evt_tx_nx;
         r_error      <= w_error_nx;
         r_err_cnt    <= w_err_cnt_nx;
      end
   end

   assign bus.start_read = r_start_read;
   assign bus.busy       = (r_state == S_READ);
   assign bus.pending    = r_pending;
   assign bus.evt_tx     = r_evt_tx;
   assign bus.error      = r_error;
   assign bus.err_cnt    = r_err_cnt;
   assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_tx_readout_sequencer.sv
// Bench for tx_readout_sequencer: directed scenarios with literal expectations
// followed by random stimulus, all checked against an event-level model.
module tb_tx_readout_sequencer;
   localparam int N  = 3;
   localparam int QD = 4;
   localparam int EW = 4;
   localparam int RW = 3;
   localparam int EMAX = (1 << RW) - 1;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   tx_readout_sequencer_if #(.N_ADC(N), .EVT_W(EW), .Q_DEPTH(QD), .ERR_W(RW)) bus ();

   tx_readout_sequencer #(.N_ADC(N), .EVT_W(EW), .Q_DEPTH(QD), .ERR_W(RW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model ----------------
   // m_cur: index of the ADC being read, -1 when no event is active
   int         m_pend;
   int         m_cur;
   int         m_evt;
   int         m_cnt;
   logic [2:0] m_err;

   always @(posedge clk or posedge reset) begin : model
      int   pend0;
      bit   idle, pop, acc;
      logic [2:0] ne;
      int   nerr;
      if (reset) begin
         m_pend = 0; m_cur = -1; m_evt = 0; m_cnt = 0; m_err = 3'b000;
      end else begin
         pend0 = m_pend;
         idle  = (m_cur < 0);
         pop   = idle && (pend0 > 0);
         acc   = 1'b0;
         ne    = 3'b000;
         if (bus.L1A_Align) begin
            if (!bus.need_read)              ne[0] = 1'b1;
            else if (pend0 < QD || pop)      acc   = 1'b1;
            else                             ne[1] = 1'b1;
         end
         if (bus.one_adc_finish_read && idle) ne[2] = 1'b1;
         if (idle) begin
            if (pop) m_cur = 0;
         end else if (bus.one_adc_finish_read) begin
            if (m_cur == N - 1) begin
               m_cur = -1;
               m_evt = (m_evt + 1) % (1 << EW);
            end else begin
               m_cur = m_cur + 1;
            end
         end
         m_pend = pend0 - int'(pop) + int'(acc);
         nerr   = int'(ne[0]) + int'(ne[1]) + int'(ne[2]);
         if (bus.err_clear) begin
            m_err = ne;
            m_cnt = (nerr > EMAX) ? EMAX : nerr;
         end else begin
            m_err = m_err | ne;
            m_cnt = (m_cnt + nerr > EMAX) ? EMAX : m_cnt + nerr;
         end
      end
   end

   function automatic logic [31:0] exp_start();
      logic [31:0] v;
      v = '0;
      if (m_cur >= 0) v[m_cur] = 1'b1;
      return v;
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      check("start_read", 32'(bus.start_read), exp_start());
      check("busy",       32'(bus.busy),       32'(m_cur >= 0));
      check("pending",    32'(bus.pending),    32'(m_pend));
      check("evt_tx",     32'(bus.evt_tx),     32'(m_evt));
      check("error",      32'(bus.error),      32'(m_err));
      check("err_cnt",    32'(bus.err_cnt),    32'(m_cnt));
   endtask

   // ---------------- driver ----------------
   task automatic cyc(input bit l1a, input bit need, input bit fin, input bit clr);
      bus.L1A_Align           = l1a;
      bus.need_read           = need;
      bus.one_adc_finish_read = fin;
      bus.err_clear           = clr;
      @(negedge clk);
      compare_model();
   endtask

   task automatic drain();
      for (int i = 0; i < 200; i++) begin
         if (!bus.busy && bus.pending == '0) break;
         cyc(1'b0, 1'b0, bus.busy, 1'b0);
      end
      check("drain_bound", {31'b0, bus.busy} | 32'(bus.pending), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      bus.L1A_Align = 1'b0;
      bus.need_read = 1'b0;
      bus.one_adc_finish_read = 1'b0;
      bus.err_clear = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_start",   32'(bus.start_read), 32'd0);
      check("rst_busy",    32'(bus.busy),       32'd0);
      check("rst_pending", 32'(bus.pending),    32'd0);
      check("rst_evt",     32'(bus.evt_tx),     32'd0);
      check("rst_error",   32'(bus.error),      32'd0);
      check("rst_errcnt",  32'(bus.err_cnt),    32'd0);
      reset = 1'b0;
      cyc(0, 0, 0, 0);

      // single event, three ADCs, finishes spaced out
      cyc(1, 1, 0, 0);
      check("one_pend",   32'(bus.pending),    32'd1);
      check("one_start0", 32'(bus.start_read), 32'd0);
      cyc(0, 0, 0, 0);
      check("one_start1", 32'(bus.start_read), 32'b001);
      cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);
      check("one_start2", 32'(bus.start_read), 32'b010);
      cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);
      check("one_start3", 32'(bus.start_read), 32'b100);
      cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);
      check("one_done",   32'(bus.start_read), 32'd0);
      check("one_evt",    32'(bus.evt_tx),     32'd1);
      check("one_err",    32'(bus.error),      32'd0);

      // L1A without data, twice
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      check("nodata_err", 32'(bus.error),      32'b001);
      check("nodata_cnt", 32'(bus.err_cnt),    32'd2);
      check("nodata_pnd", 32'(bus.pending),    32'd0);
      check("nodata_sr",  32'(bus.start_read), 32'd0);
      cyc(0, 0, 0, 1);

      // overflow: one event in READ, five more L1As
      cyc(1, 1, 0, 0);
      cyc(0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0);
      check("ovf_pend", 32'(bus.pending), 32'd4);
      check("ovf_err",  32'(bus.error),   32'b010);
      check("ovf_cnt",  32'(bus.err_cnt), 32'd1);
      drain();
      check("ovf_evt",  32'(bus.evt_tx),  32'd6);
      cyc(0, 0, 0, 1);

      // idle finish coincident with dataless L1A, then clear
      cyc(1, 0, 1, 0);
      check("co_err", 32'(bus.error),   32'b101);
      check("co_cnt", 32'(bus.err_cnt), 32'd2);
      cyc(0, 0, 0, 1);
      check("clr_err", 32'(bus.error),   32'd0);
      check("clr_cnt", 32'(bus.err_cnt), 32'd0);

      // error counter saturation (2,4,6,7,7)
      for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0);
      check("sat_cnt", 32'(bus.err_cnt), 32'd7);
      // clear with same-cycle errors: count equals that cycle's increment
      cyc(1, 0, 1, 1);
      check("clrwin_err", 32'(bus.error),   32'b101);
      check("clrwin_cnt", 32'(bus.err_cnt), 32'd2);
      cyc(0, 0, 0, 1);

      // evt_tx wrap: 6 + 10 events = 16 -> 0
      for (int i = 0; i < 10; i++) begin
         cyc(1, 1, 0, 0);
         drain();
      end
      check("wrap_evt", 32'(bus.evt_tx), 32'd0);

      // async reset during READ with two pending
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      check("prerst_pend", 32'(bus.pending), 32'd2);
      check("prerst_busy", 32'(bus.busy),    32'd1);
      bus.L1A_Align = 1'b0;
      bus.need_read = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("arst_start", 32'(bus.start_read), 32'd0);
      check("arst_busy",  32'(bus.busy),       32'd0);
      check("arst_pend",  32'(bus.pending),    32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
      check("post_rst_sr", 32'(bus.start_read), 32'd0);

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
